// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (ADD..MUL)
//   - FSM state encoding (IDLE/EXEC/DONE)
//   - bit positions inside the registered flag vector
// Optional feature: ALU_SEQ_MUL_EN (multiplier). The encoding of OP_MUL is
// always present; whether it is legal is decided in alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_ERR = 2;
  localparam int FLAG_W   = 3;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control FSM (master) and
// the sequential ALU (slave).
//   master drives : start, alu_sel, accum, alu_in
//   slave drives  : busy, done, result, result_hi, z, c, err
interface alu_seq_if #(parameter int WIDTH = 8);

  logic             start;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] accum;
  logic [WIDTH-1:0] alu_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             z;
  logic             c;
  logic             err;

  modport master (
    output start, alu_sel, accum, alu_in,
    input  busy, done, result, result_hi, z, c, err
  );

  modport slave (
    input  start, alu_sel, accum, alu_in,
    output busy, done, result, result_hi, z, c, err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier.
// Only compiled when ALU_SEQ_MUL_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   load       : capture a/b and process multiplier bit 0 in the same edge
//   step       : process the next multiplier bit
//   a, b       : operands (sampled on load)
//   product    : running product; complete after load + (WIDTH-1) steps
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] a_ext_s;

  assign a_ext_s = {{WIDTH{1'b0}}, a};

  // Accumulate one partial product per load/step; bit 0 is folded into load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {2*WIDTH{1'b0}};
      mcand_r  <= {2*WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
    end else if (load) begin
      acc_r    <= b[0] ? a_ext_s : {2*WIDTH{1'b0}};
      mcand_r  <= {a_ext_s[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, b[WIDTH-1:1]};
    end else if (step) begin
      acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {2*WIDTH{1'b0}});
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
    end
  end

  assign product = acc_r;

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with start/busy/done handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts an operation, no done)
//   bus   : alu_seq_if.slave - start/alu_sel/accum/alu_in in,
//           busy/done/result/result_hi/z/c/err out
// ADD/SUB/NOR/MOVR and illegal opcodes complete one cycle after accept;
// SHL/SHR shift one bit per EXEC cycle; MUL (ALU_SEQ_MUL_EN defined) uses
// alu_mul_iter and completes WIDTH+1 cycles after accept. Without the
// macro, MUL is an illegal opcode and result_hi stays 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_r, state_s;
  logic [3:0]       op_r, op_s;
  logic [WIDTH-1:0] sh_r, sh_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [WIDTH-1:0] result_hi_r, result_hi_s;
  logic [FLAG_W-1:0] flags_r, flags_s;
  logic [WIDTH-1:0] shv_s;
  logic             shout_s;
  logic [WIDTH+1:0] single_s;

`ifdef ALU_SEQ_MUL_EN
  logic               mul_load_s;
  logic               mul_step_s;
  logic [2*WIDTH-1:0] product_s;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load_s),
    .step    (mul_step_s),
    .a       (bus.accum),
    .b       (bus.alu_in),
    .product (product_s)
  );
`endif

  // Single-cycle ops; packed as {err, c, result}. Illegal opcodes land in default.
  function automatic logic [WIDTH+1:0] single_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  return {1'b0, sum};
      OP_SUB:  return {1'b0, (a < b), a - b};
      OP_NOR:  return {2'b00, ~(a | b)};
      OP_MOVR: return {2'b00, b};
      default: return {1'b1, 1'b0, {WIDTH{1'b0}}};
    endcase
  endfunction

  // One-bit shift of the working register and the bit that falls out.
  always_comb begin
    if (op_r == OP_SHL) begin
      shout_s = sh_r[WIDTH-1];
      shv_s   = {sh_r[WIDTH-2:0], 1'b0};
    end else begin
      shout_s = sh_r[0];
      shv_s   = {1'b0, sh_r[WIDTH-1:1]};
    end
  end

  assign single_s = single_op(bus.alu_sel, bus.accum, bus.alu_in);

  // Next-state, operand capture and completion values.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    sh_s        = sh_r;
    cnt_s       = cnt_r;
    result_s    = result_r;
    result_hi_s = result_hi_r;
    flags_s     = flags_r;
`ifdef ALU_SEQ_MUL_EN
    mul_load_s  = 1'b0;
    mul_step_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          op_s  = bus.alu_sel;
          sh_s  = bus.accum;
          cnt_s = {1'b0, bus.alu_in[SHAMT_W-1:0]};
          if (is_shift(bus.alu_sel)) begin
            if (bus.alu_in[SHAMT_W-1:0] == {SHAMT_W{1'b0}}) begin
              // Shift by zero completes immediately with A unchanged.
              state_s           = ST_DONE;
              result_s          = bus.accum;
              result_hi_s       = {WIDTH{1'b0}};
              flags_s[FLAG_Z]   = (bus.accum == {WIDTH{1'b0}});
              flags_s[FLAG_C]   = 1'b0;
              flags_s[FLAG_ERR] = 1'b0;
            end else begin
              state_s = ST_EXEC;
            end
          end
`ifdef ALU_SEQ_MUL_EN
          else if (bus.alu_sel == OP_MUL) begin
            state_s    = ST_EXEC;
            cnt_s      = CNT_W'(WIDTH);
            mul_load_s = 1'b1;
          end
`endif
          else begin
            state_s           = ST_DONE;
            result_s          = single_s[WIDTH-1:0];
            result_hi_s       = {WIDTH{1'b0}};
            flags_s[FLAG_C]   = single_s[WIDTH];
            flags_s[FLAG_ERR] = single_s[WIDTH+1];
            // Illegal opcodes report z=0 even though result is 0.
            flags_s[FLAG_Z]   = ~single_s[WIDTH+1] &
                                (single_s[WIDTH-1:0] == {WIDTH{1'b0}});
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
`ifdef ALU_SEQ_MUL_EN
        // Load handled bit 0, so WIDTH-1 steps then one cycle to publish.
        if (op_r == OP_MUL) begin
          if (cnt_r == CNT_ONE) begin
            state_s           = ST_DONE;
            result_s          = product_s[WIDTH-1:0];
            result_hi_s       = product_s[2*WIDTH-1:WIDTH];
            flags_s[FLAG_Z]   = (product_s == {2*WIDTH{1'b0}});
            flags_s[FLAG_C]   = |product_s[2*WIDTH-1:WIDTH];
            flags_s[FLAG_ERR] = 1'b0;
          end else begin
            mul_step_s = 1'b1;
            cnt_s      = cnt_r - CNT_ONE;
          end
        end else
`endif
        begin
          sh_s = shv_s;
          if (cnt_r == CNT_ONE) begin
            state_s           = ST_DONE;
            result_s          = shv_s;
            result_hi_s       = {WIDTH{1'b0}};
            flags_s[FLAG_Z]   = (shv_s == {WIDTH{1'b0}});
            flags_s[FLAG_C]   = shout_s;
            flags_s[FLAG_ERR] = 1'b0;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= 4'b0000;
      sh_r        <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      flags_r     <= {FLAG_W{1'b0}};
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      sh_r        <= sh_s;
      cnt_r       <= cnt_s;
      result_r    <= result_s;
      result_hi_r <= result_hi_s;
      flags_r     <= flags_s;
    end
  end

  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.done      = (state_r == ST_DONE);
  assign bus.result    = result_r;
  assign bus.result_hi = result_hi_r;
  assign bus.z         = flags_r[FLAG_Z];
  assign bus.c         = flags_r[FLAG_C];
  assign bus.err       = flags_r[FLAG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8).
// A behavioural model predicts each accepted request's outputs and latency
// from plain integer arithmetic; a monitor compares every DUT output on
// every falling edge. Directed literal cases pin the model.
module tb_alu_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         lat;
    logic [7:0] res;
    logic [7:0] hi;
    logic       z;
    logic       c;
    logic       err;
  } exp_t;

  typedef struct {
    int   due;
    exp_t e;
  } pend_t;

  pend_t q[$];

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t e;
    int ai, bi, k, full;
    ai = int'(a);
    bi = int'(b);
    k  = bi % 8;
    e.lat = 1; e.res = 8'h00; e.hi = 8'h00; e.c = 1'b0; e.err = 1'b0;
    case (op)
      4'd1:  begin full = ai + bi; e.res = 8'(full); e.c = (full > 255); end
      4'd2:  begin e.res = 8'(ai - bi); e.c = (ai < bi); end
      4'd3:  e.res = ~(a | b);
      4'd4:  e.res = b;
      4'd11: begin
        e.res = 8'(ai << k);
        e.c   = (k == 0) ? 1'b0 : (((ai >> (8 - k)) & 1) == 1);
        e.lat = 1 + k;
      end
      4'd12: begin
        e.res = 8'(ai >> k);
        e.c   = (k == 0) ? 1'b0 : (((ai >> (k - 1)) & 1) == 1);
        e.lat = 1 + k;
      end
`ifdef ALU_SEQ_MUL_EN
      4'd13: begin
        full = ai * bi; e.res = 8'(full); e.hi = 8'(full >> 8);
        e.c = (full > 255); e.lat = 9;
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.z = !e.err && (e.res == 8'h00) && (e.hi == 8'h00);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: model of accept/busy/done timing plus held output values.
  initial begin : monitor
    int cyc, last_due;
    logic [7:0] lr, lh;
    logic lz, lc, le, busy_x, done_x;
    exp_t e;
    pend_t p;
    cyc = 0; last_due = -1;
    lr = 8'h00; lh = 8'h00; lz = 1'b0; lc = 1'b0; le = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        last_due = -1;
        lr = 8'h00; lh = 8'h00; lz = 1'b0; lc = 1'b0; le = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags", {29'd0, bus.z, bus.c, bus.err}, 32'd0);
      end else begin
        busy_x = (cyc <= last_due);
        done_x = (q.size() > 0) && (q[0].due == cyc);
        if (done_x) begin
          e = q[0].e;
          q.pop_front();
          lr = e.res; lh = e.hi; lz = e.z; lc = e.c; le = e.err;
        end
        chk("busy", 32'(bus.busy), 32'(busy_x));
        chk("done", 32'(bus.done), 32'(done_x));
        chk("result", 32'(bus.result), 32'(lr));
        chk("result_hi", 32'(bus.result_hi), 32'(lh));
        chk("z", 32'(bus.z), 32'(lz));
        chk("c", 32'(bus.c), 32'(lc));
        chk("err", 32'(bus.err), 32'(le));
        if (bus.start && !busy_x) begin
          e = model(bus.alu_sel, bus.accum, bus.alu_in);
          p.due = cyc + e.lat;
          p.e = e;
          q.push_back(p);
          last_due = cyc + e.lat;
        end
      end
    end
  end

  task automatic drive(input logic s, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    @(posedge clk);
    #2;
    bus.start = s; bus.alu_sel = op; bus.accum = a; bus.alu_in = b;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 after 40 cycles");
    end
  endtask

  // One request with start pulsed for a single cycle, checked against literals.
  task automatic directed(input string name, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int lat_e, input logic [7:0] res_e,
                          input logic [7:0] hi_e, input logic z_e, input logic c_e,
                          input logic err_e);
    int lat;
    wait_idle();
    drive(1'b1, op, a, b);
    drive(1'b0, op, a, b);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done within 40 cycles", name);
    end else begin
      chk({name, "_lat"}, 32'(lat), 32'(lat_e));
      chk({name, "_res"}, 32'(bus.result), 32'(res_e));
      chk({name, "_hi"}, 32'(bus.result_hi), 32'(hi_e));
      chk({name, "_zce"}, {29'd0, bus.z, bus.c, bus.err}, {29'd0, z_e, c_e, err_e});
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stim
    int dones;
    logic [3:0] ops[9];
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd12, 4'd13, 4'd0, 4'd15};
    rst_n = 1'b0;
    bus.start = 1'b0; bus.alu_sel = 4'd0; bus.accum = 8'h00; bus.alu_in = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    directed("movr_pre", 4'd4, 8'h00, 8'h5A, 1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of SHL by 5 clears everything and yields no done.
    wait_idle();
    drive(1'b1, 4'd11, 8'hA3, 8'd5);
    drive(1'b0, 4'd11, 8'hA3, 8'd5);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_flags", {29'd0, bus.z, bus.c, bus.err}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);

    directed("add_ff_01", 4'd1, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    directed("sub_3_5", 4'd2, 8'h03, 8'h05, 1, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
    directed("sub_5_5", 4'd2, 8'h05, 8'h05, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    directed("nor", 4'd3, 8'hF0, 8'h0C, 1, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
    directed("shl_81_3", 4'd11, 8'h81, 8'd3, 4, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    directed("shr_81_1", 4'd12, 8'h81, 8'd1, 2, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
    directed("shl_81_0", 4'd11, 8'h81, 8'd0, 1, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    directed("shl_hibits", 4'd11, 8'h81, 8'hF9, 2, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0);
    directed("shr_80_7", 4'd12, 8'h80, 8'd7, 8, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ_MUL_EN
    directed("mul_ff_ff", 4'd13, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0);
    directed("mul_0", 4'd13, 8'h00, 8'h37, 9, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
`else
    directed("mul_off", 4'd13, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
    directed("illegal_0", 4'd0, 8'h12, 8'h34, 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    directed("movr_clr", 4'd4, 8'h00, 8'h5A, 1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);

    // start held high: operands changed after accept, no accept in done cycle.
    wait_idle();
    drive(1'b1, 4'd4, 8'h00, 8'h11);
    @(posedge clk);
    #2 bus.alu_in = 8'h22;
    @(negedge clk);
    chk("hold_done1", 32'(bus.done), 32'd1);
    chk("hold_res1", 32'(bus.result), 32'h11);
    @(negedge clk);
    chk("hold_gap", {30'd0, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    chk("hold_done2", 32'(bus.done), 32'd1);
    chk("hold_res2", 32'(bus.result), 32'h22);
    drive(1'b0, 4'd4, 8'h00, 8'h22);

    // Random traffic: start and operands change freely, including while busy.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 2) != 0), ops[$urandom_range(0, 8)],
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
